proc_launcher: RTL and testbench
================================

# proc_launcher

Host-side initiator for the 9-bit-instruction processor core. It owns the core's `req`/`done` handshake: preloads operand words into data memory, holds and releases the core's reset, issues `req` with a selected entry point, and counts cycles until `done`. It then streams result words back out of data memory. It sits between the host/testbench and the core plus `dat_mem`, and drives the memory port through a select mux while the core is held in reset.

## Interface
Parameters:
- `LD_N`, 8: operand words preloaded per run (≥1)
- `LD_BASE`, 8'd0: first preload address
- `OUT_N`, 4: result words read back per run (≥1)
- `OUT_BASE`, 8'd64: first readback address
- `RST_CYC`, 2: cycles `core_reset` is held in the RST state (≥1)
- `TIMEOUT`, 4096: RUN-cycle limit (watchdog builds only)
- `CW`, 16: cycle-counter width

Ports:
- `clk` in 1: clock
- `reset` in 1: asynchronous, active-low reset
- `start` in 1: host launch request, sampled in IDLE only
- `prog_sel` in 2: entry point, latched on accepted `start`
- `ld_valid` in 1, `ld_ready` out 1, `ld_data` in 8: operand input stream
- `out_valid` out 1, `out_ready` in 1, `out_data` out 8: result output stream
- `busy` out 1: high in every state except IDLE
- `finished` out 1: one-cycle pulse on return to IDLE
- `timeout` out 1: sticky, set when the watchdog expires; cleared on next accepted `start`
- `cycle_count` out CW: RUN-cycle count of the last run
- `core_reset` out 1: active-high synchronous reset to the core
- `req` out 1, `jump_addr` out 2: to the core
- `done` in 1: from the core
- `mem_sel` out 1: 1 means the launcher owns the `dat_mem` port
- `mem_wr_en` out 1, `mem_addr` out 8, `mem_wdata` out 8, `mem_rdata` in 8: `dat_mem` port, combinational read, write on posedge

## Operation
States are IDLE, LOAD, RST, REQ, RUN, UNLOAD.

- **IDLE**
  - `core_reset`=1, `mem_sel`=0.
  - `start`=1 latches `prog_sel`, clears `timeout` and the word index, and moves to LOAD.
- **LOAD**
  - `mem_sel`=1, `ld_ready`=1.
  - On `ld_valid && ld_ready`: `mem_wr_en`=1, `mem_addr`=`LD_BASE`+i, `mem_wdata`=`ld_data`, i++.
  - After word `LD_N`-1 is accepted, go to RST.
  - Stalls indefinitely while `ld_valid`=0.
- **RST**
  - `mem_sel`=0, `core_reset`=1 for `RST_CYC` cycles, then go to REQ.
- **REQ**
  - `core_reset`=0, `req`=1 for exactly one cycle.
  - `jump_addr` = latched `prog_sel`, driven from REQ until the next IDLE.
  - Clears `cycle_count`, then go to RUN.
- **RUN**
  - `core_reset`=0.
  - Each cycle with `done`=0: `cycle_count`++ (saturates at all-ones).
  - `done`=1: go to UNLOAD with the count frozen.
  - Watchdog builds: when `cycle_count` reaches `TIMEOUT` with `done`=0, set `timeout` and go to IDLE, skipping UNLOAD.
  - `done` and the expiry in the same cycle: `done` wins.
- **UNLOAD**
  - `core_reset`=1, `mem_sel`=1, `mem_addr`=`OUT_BASE`+k.
  - `out_valid`=1, `out_data`=`mem_rdata` (combinational).
  - On `out_valid && out_ready`: k++.
  - After word `OUT_N`-1 is taken, go to IDLE.
  - `out_data` is stable while stalled because the core is held in reset.
- **Return to IDLE:** `finished` pulses for one cycle, from UNLOAD or on timeout.
- **Index arithmetic:** address = base + index, modulo 256; wrap past 8'hFF is permitted.
- **Reset:** asynchronous assertion mid-operation aborts to IDLE immediately. Outputs return to reset values and memory contents are untouched.
- **Back-to-back:** `start` in the cycle after `finished` launches a new run.

## Timing
- Reset values:
  - `core_reset`=1.
  - All others 0: `req`, `jump_addr`, `busy`, `finished`, `timeout`, `cycle_count`, `ld_ready`, `out_valid`, `out_data`, `mem_sel`, `mem_wr_en`, `mem_addr`, `mem_wdata`.
- `start` → LOAD: 1 cycle. `ld_ready` is high in the cycle after `start` is sampled.
- Load throughput: 1 word per cycle.
- Last load → `req`: `RST_CYC`+1 cycles.
- `req` → RUN: next cycle. `done` is sampled from the first RUN cycle.
- `done` high → first `out_valid`: 1 cycle.
- Unload throughput: 1 word per cycle.
- All outputs are registered, except `out_data`, `mem_addr`/`mem_wdata`/`mem_wr_en` in LOAD/UNLOAD, and `ld_ready`/`out_valid`, which are state-decoded.

## Configuration
- `PROC_LAUNCHER_TIMEOUT_EN` defined: the watchdog described above is built.
- Not defined: RUN waits for `done` forever, `timeout` is tied to 0, and `TIMEOUT` is unused.

## Test plan
- **Nominal run**
  - Stimulus: `prog_sel`=2'b01, stream 8 operands 8'h10..8'h17 without stalls, core model raises `done` 37 cycles after `req`.
  - Required: mem[0..7]=8'h10..8'h17, `req` high exactly one cycle with `jump_addr`=2'b01, `cycle_count`=37, 4 words streamed from mem[64..67], one `finished` pulse.
- **Load stalls**
  - Stimulus: `ld_valid` low for 3 cycles between each word.
  - Required: exactly 8 writes at addresses 0..7, no write while `ld_valid`=0, `core_reset` held high throughout LOAD.
- **Unload backpressure**
  - Stimulus: `out_ready` low for 5 cycles at word 2.
  - Required: `out_data` = mem[66] held stable, k does not advance, 4 words total.
- **Timeout** (macro on, `TIMEOUT`=100)
  - Stimulus: `done` never asserted.
  - Required: `timeout`=1 after 100 RUN cycles, no `out_valid`, `finished` pulses, `core_reset`=1. A subsequent `start` clears `timeout`.
- **Simultaneous done/expiry**
  - Stimulus: `done` rises in the cycle the count reaches `TIMEOUT`.
  - Required: UNLOAD is entered and `timeout` stays 0.
- **Reset mid-RUN**
  - Stimulus: drive `reset`=0 for 1 cycle during RUN.
  - Required: immediate IDLE, `core_reset`=1, `busy`=0, `cycle_count`=0. `start` while busy is ignored.

Source files
------------

// File: rtl/proc_launcher.sv
// proc_launcher: preloads dat_mem, launches the core via req/done, times the run, streams results out (watchdog: PROC_LAUNCHER_TIMEOUT_EN).
// Latency: start->ld_ready 1 cycle, last load->req RST_CYC+1 cycles, done->first out_valid 1 cycle.
// Backpressure: ld_valid low stalls LOAD, out_ready low holds UNLOAD on the same word; start is ignored while busy.
module proc_launcher #(
    parameter int          LD_N     = 8,
    parameter logic [7:0]  LD_BASE  = 8'd0,
    parameter int          OUT_N    = 4,
    parameter logic [7:0]  OUT_BASE = 8'd64,
    parameter int          RST_CYC  = 2,
    parameter int          TIMEOUT  = 4096,
    parameter int          CW       = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    prog_sel,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [7:0]    ld_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic          busy,
    output logic          finished,
    output logic          timeout,
    output logic [CW-1:0] cycle_count,
    output logic          core_reset,
    output logic          req,
    output logic [1:0]    jump_addr,
    input  logic          done,
    output logic          mem_sel,
    output logic          mem_wr_en,
    output logic [7:0]    mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RST, S_REQ, S_RUN, S_UNLOAD} state_t;

    localparam int            IW     = 16;
    localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);
`ifdef PROC_LAUNCHER_TIMEOUT_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    state_t        state;
    logic [IW-1:0] idx;     // load word, reset-hold cycle, or unload word, depending on state
    logic [1:0]    sel_q;
    logic [CW-1:0] cnt_next;
    logic          expire;

    assign cnt_next = (&cycle_count) ? cycle_count : cycle_count + CW'(1);
    assign expire   = WD_EN && (cnt_next == TO_LIM);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            sel_q       <= 2'd0;
            core_reset  <= 1'b1;
            req         <= 1'b0;
            jump_addr   <= 2'd0;
            busy        <= 1'b0;
            finished    <= 1'b0;
            cycle_count <= '0;
            mem_sel     <= 1'b0;
        end else begin
            finished <= 1'b0;
            req      <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    sel_q   <= prog_sel;
                    idx     <= '0;
                    busy    <= 1'b1;
                    mem_sel <= 1'b1;
                    state   <= S_LOAD;
                end
                S_LOAD: if (ld_valid) begin
                    idx <= idx + IW'(1);
                    if (idx == IW'(LD_N - 1)) begin
                        idx     <= '0;
                        mem_sel <= 1'b0;
                        state   <= S_RST;
                    end
                end
                S_RST: begin
                    idx <= idx + IW'(1);
                    if (idx == IW'(RST_CYC - 1)) begin
                        core_reset <= 1'b0;
                        req        <= 1'b1;
                        jump_addr  <= sel_q;
                        state      <= S_REQ;
                    end
                end
                S_REQ: begin
                    cycle_count <= '0;
                    state       <= S_RUN;
                end
                S_RUN: begin
                    // done takes priority over a watchdog expiry in the same cycle
                    if (done) begin
                        core_reset <= 1'b1;
                        mem_sel    <= 1'b1;
                        idx        <= '0;
                        state      <= S_UNLOAD;
                    end else begin
                        cycle_count <= cnt_next;
                        if (expire) begin
                            core_reset <= 1'b1;
                            jump_addr  <= 2'd0;
                            busy       <= 1'b0;
                            finished   <= 1'b1;
                            state      <= S_IDLE;
                        end
                    end
                end
                S_UNLOAD: if (out_ready) begin
                    idx <= idx + IW'(1);
                    if (idx == IW'(OUT_N - 1)) begin
                        mem_sel   <= 1'b0;
                        jump_addr <= 2'd0;
                        busy      <= 1'b0;
                        finished  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef PROC_LAUNCHER_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            timeout <= 1'b0;
        else if (state == S_IDLE && start)
            timeout <= 1'b0;
        else if (state == S_RUN && !done && expire)
            timeout <= 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    // memory port and stream handshakes follow the state directly
    always_comb begin
        ld_ready  = (state == S_LOAD);
        out_valid = (state == S_UNLOAD);
        mem_wr_en = 1'b0;
        mem_addr  = 8'd0;
        mem_wdata = 8'd0;
        out_data  = 8'd0;
        if (state == S_LOAD) begin
            mem_wr_en = ld_valid;
            mem_addr  = LD_BASE + idx[7:0];
            mem_wdata = ld_data;
        end else if (state == S_UNLOAD) begin
            mem_addr = OUT_BASE + idx[7:0];
            out_data = mem_rdata;
        end
    end

endmodule

// File: tb/tb_proc_launcher.sv
// Randomized bench for proc_launcher: dat_mem and core behaviour modelled here, run outcome predicted from the launcher rules.
module tb_proc_launcher;
    localparam int         LD_N     = 8;
    localparam int         OUT_N    = 4;
    localparam int         RST_CYC  = 2;
    localparam int         TMO      = 100;
    localparam int         CW       = 16;
    localparam logic [7:0] LD_BASE  = 8'd0;
    localparam logic [7:0] OUT_BASE = 8'd64;
`ifdef PROC_LAUNCHER_TIMEOUT_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    prog_sel = 2'd0;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic [7:0]    ld_data = 8'd0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [7:0]    out_data;
    logic          busy, finished, timeout;
    logic [CW-1:0] cycle_count;
    logic          core_reset, req;
    logic [1:0]    jump_addr;
    logic          done = 1'b0;
    logic          mem_sel, mem_wr_en;
    logic [7:0]    mem_addr, mem_wdata, mem_rdata;

    logic [7:0] mem [256] = '{default: 8'h00};
    logic [7:0] res [OUT_N];
    int checks = 0;
    int errors = 0;

    proc_launcher #(
        .LD_N(LD_N), .LD_BASE(LD_BASE), .OUT_N(OUT_N), .OUT_BASE(OUT_BASE),
        .RST_CYC(RST_CYC), .TIMEOUT(TMO), .CW(CW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .prog_sel(prog_sel),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .finished(finished), .timeout(timeout), .cycle_count(cycle_count),
        .core_reset(core_reset), .req(req), .jump_addr(jump_addr), .done(done),
        .mem_sel(mem_sel), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // dat_mem: launcher writes through the mux; the core deposits its results while launched
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_sel && mem_wr_en)
            mem[mem_addr] <= mem_wdata;
        if (req && !mem_sel)
            for (int j = 0; j < OUT_N; j++)
                mem[8'(OUT_BASE + j)] <= res[j];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One launch. done_after = RUN cycles with done low before done is raised (-1: never).
    task automatic run(input logic [1:0] sel, input bit seq_ops, input int gap_lo, input int gap_hi,
                       input int stall_k, input int stall_len, input int done_after,
                       input int abort_at, input bit poke_start);
        logic [7:0] ops [LD_N];
        int bad, n, c, lim, g;
        bit exp_to;
        for (int j = 0; j < LD_N; j++) ops[j] = seq_ops ? 8'(8'h10 + j) : 8'($urandom);
        for (int j = 0; j < OUT_N; j++)
            res[j] = (ops[(2*j) % LD_N] ^ ops[(2*j+1) % LD_N]) + 8'(sel) + 8'(j);

        check_eq("idle_busy", {31'd0, busy}, 32'd0);
        start = 1'b1; prog_sel = sel;
        tick();
        start = 1'b0; prog_sel = 2'($urandom);
        #1;
        check_eq("load_ready", {31'd0, ld_ready}, 32'd1);
        check_eq("load_timeout_clr", {31'd0, timeout}, 32'd0);
        check_eq("finished_one_pulse", {31'd0, finished}, 32'd0);

        bad = 0;
        for (int j = 0; j < LD_N; j++) begin
            g = $urandom_range(gap_hi, gap_lo);
            for (int s = 0; s < g; s++) begin
                ld_valid = 1'b0; ld_data = 8'($urandom);
                #1;
                if (mem_wr_en || !core_reset || !ld_ready || !mem_sel) bad++;
                tick();
            end
            ld_valid = 1'b1; ld_data = ops[j];
            #1;
            if (!mem_wr_en || mem_addr !== 8'(LD_BASE + j) || mem_wdata !== ops[j] || !core_reset) bad++;
            tick();
        end
        ld_valid = 1'b0;
        check_eq("load_protocol", bad, 0);
        bad = 0;
        for (int j = 0; j < LD_N; j++) if (mem[8'(LD_BASE + j)] !== ops[j]) bad++;
        check_eq("load_mem_contents", bad, 0);

        n = 1; bad = 0;
        #1;
        while (!req && n < 20) begin
            if (mem_sel || !core_reset || ld_ready) bad++;
            tick(); #1; n++;
        end
        check_eq("rst_hold", bad, 0);
        check_eq("last_load_to_req", n, RST_CYC + 1);
        check_eq("req_jump_addr", {30'd0, jump_addr}, {30'd0, sel});
        check_eq("req_core_reset", {31'd0, core_reset}, 32'd0);
        tick(); #1;
        check_eq("req_single_cycle", {31'd0, req}, 32'd0);

        exp_to = WD && (done_after < 0 || done_after >= TMO);
        lim = (done_after < 0) ? TMO + 50 : done_after;
        c = 0; bad = 0;
        while (c < lim) begin
            if (exp_to && c == TMO) break;
            done = 1'b0;
            start = poke_start && (c == 1);
            #1;
            if (core_reset || !busy || out_valid || jump_addr !== sel) bad++;
            if (c == abort_at) begin
                start = 1'b0;
                reset = 1'b0;
                #1;
                check_eq("abort_busy", {31'd0, busy}, 32'd0);
                check_eq("abort_core_reset", {31'd0, core_reset}, 32'd1);
                check_eq("abort_cycle_count", {16'd0, cycle_count}, 32'd0);
                check_eq("abort_outputs", {27'd0, req, jump_addr, mem_sel, ld_ready}, 32'd0);
                tick();
                reset = 1'b1;
                bad = 0;
                for (int j = 0; j < LD_N; j++) if (mem[8'(LD_BASE + j)] !== ops[j]) bad++;
                check_eq("abort_mem_kept", bad, 0);
                return;
            end
            tick();
            c++;
        end
        start = 1'b0;
        check_eq("run_phase", bad, 0);

        if (exp_to) begin
            #1;
            check_eq("to_timeout", {31'd0, timeout}, 32'd1);
            check_eq("to_finished", {31'd0, finished}, 32'd1);
            check_eq("to_core_reset", {31'd0, core_reset}, 32'd1);
            check_eq("to_busy", {31'd0, busy}, 32'd0);
            check_eq("to_count", {16'd0, cycle_count}, TMO);
            check_eq("to_no_out_valid", {31'd0, out_valid}, 32'd0);
            return;
        end

        done = 1'b1;
        tick();
        done = 1'b0;
        #1;
        check_eq("done_to_out_valid", {31'd0, out_valid}, 32'd1);
        check_eq("unload_core_reset", {31'd0, core_reset}, 32'd1);
        check_eq("unload_timeout", {31'd0, timeout}, 32'd0);
        check_eq("cycle_count", {16'd0, cycle_count}, done_after);

        bad = 0;
        for (int k = 0; k < OUT_N; k++) begin
            if (k == stall_k) begin
                for (int s = 0; s < stall_len; s++) begin
                    out_ready = 1'b0;
                    #1;
                    if (!out_valid || out_data !== res[k] || mem_addr !== 8'(OUT_BASE + k)) bad++;
                    tick();
                end
            end
            out_ready = 1'b1;
            #1;
            if (!out_valid || out_data !== res[k] || mem_addr !== 8'(OUT_BASE + k) || jump_addr !== sel) bad++;
            tick();
        end
        out_ready = 1'b0;
        #1;
        check_eq("unload_stream", bad, 0);
        check_eq("end_finished", {31'd0, finished}, 32'd1);
        check_eq("end_idle", {29'd0, busy, out_valid, core_reset}, 32'd1);
        check_eq("end_count_held", {16'd0, cycle_count}, done_after);
    endtask

    initial begin
        #2 reset = 1'b0;
        #1;
        check_eq("rst_core_reset", {31'd0, core_reset}, 32'd1);
        check_eq("rst_ctrl", {24'd0, req, jump_addr, busy, finished, timeout, ld_ready, out_valid}, 32'd0);
        check_eq("rst_count", {16'd0, cycle_count}, 32'd0);
        check_eq("rst_mem_port", {7'd0, mem_sel, mem_wr_en, mem_addr, mem_wdata, out_data}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run(2'b01, 1'b1, 0, 0, -1, 0, 37, -1, 1'b0);           // nominal
        run(2'b10, 1'b0, 3, 3, -1, 0, 20, -1, 1'b0);           // load stalls
        run(2'b11, 1'b0, 0, 1, 2, 5, 15, -1, 1'b0);            // unload backpressure
        run(2'b00, 1'b0, 0, 0, -1, 0, TMO - 1, -1, 1'b0);      // done in the cycle the count reaches TMO
`ifdef PROC_LAUNCHER_TIMEOUT_EN
        run(2'b01, 1'b0, 0, 0, -1, 0, -1, -1, 1'b0);           // watchdog expiry
        run(2'b10, 1'b0, 0, 1, -1, 0, 12, -1, 1'b0);           // timeout cleared by next start
`endif
        run(2'b11, 1'b0, 0, 0, -1, 0, 40, 10, 1'b0);           // reset mid-RUN
        run(2'b01, 1'b0, 0, 0, -1, 0, 9, -1, 1'b1);            // start while busy ignored
        for (int r = 0; r < 8; r++)
            run(2'($urandom), 1'b0, 0, 2, $urandom_range(OUT_N - 1, 0), $urandom_range(3, 0),
                $urandom_range(60, 1), -1, 1'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit got=running expected=finished");
        $fatal(1, "time limit");
    end
endmodule
